dpsk_nco_sched: RTL and testbench
=================================

Name: dpsk_nco_sched

Overview:
Symbol scheduler that sequences the NCO for the DPSK modulator.
- Latches frequency configuration and gates the NCO clock enable.
- Waits out NCO pipeline latency, then paces symbols with a symbol-period counter.
- Accepts source bits through a valid/ready handshake and differentially encodes them.
- Drives the NCO phase-modulation input with the encoded phase offset.
- Sits between the bit source and the dds NCO instance.

Parameters:
ACC_W, 34, NCO phase accumulator width; width of phi_inc and phase-mod words.
LEN_W, 16, width of the symbol-length configuration.

Ports:
clk  in  1  system clock.
reset_n  in  1  asynchronous active-low reset.
enable  in  1  level; high requests modulation, low requests stop.
cfg_phi_inc  in  ACC_W  carrier phase increment; latched on IDLE->PRIME.
cfg_sym_len  in  LEN_W  clocks per symbol; latched on IDLE->PRIME; 0 treated as 1.
bit_data  in  1 (2 with DQPSK_MODE_EN)  source symbol bits.
bit_valid  in  1  source has a symbol.
bit_ready  out  1  scheduler accepts a symbol this cycle.
nco_phi_inc  out  ACC_W  drives NCO phi_inc_i.
nco_phase_mod  out  ACC_W  drives NCO phase-modulation input.
nco_clken  out  1  drives NCO clken.
nco_valid  in  1  NCO out_valid.
sym_strobe  out  1  one-cycle pulse when a new phase is applied.
busy  out  1  high in any state other than IDLE.
underrun  out  1  sticky; source had no symbol at a boundary.

Behaviour:
- Reset (async, reset_n low): state IDLE; all outputs 0; counter 0; diff state d 0.
- Accept condition is bit_valid && bit_ready. bit_ready is combinational, high only on boundary cycles in RUN.
- IDLE: nco_clken=0, bit_ready=0.
  - On enable=1: latch cfg_phi_inc into nco_phi_inc and L=max(cfg_sym_len,1); clear underrun and d; go to PRIME.
- PRIME: nco_clken=1, nco_phase_mod=0.
  - enable=0: go to IDLE next cycle.
  - Else, on the first cycle nco_valid=1: go to RUN with counter=0. This first symbol is the phase reference.
- RUN: nco_clken=1; counter increments by 1 each clock, wrapping at L-1.
  - Boundary is counter==L-1. On a boundary with enable=1: bit_ready=1.
    - If bit_valid: d <= d XOR bit_data.
    - Else: bit 0 is inserted, d is unchanged, underrun <= 1.
  - The cycle after every boundary: nco_phase_mod <= d ? 2^(ACC_W-1) : 0, and sym_strobe=1. The pulse occurs even on underrun.
  - Boundary with enable=0: bit_ready=0, no bit accepted, go to IDLE (nco_clken=0 next cycle). The current symbol always completes.
  - nco_valid is ignored in RUN.
- Latency: accepted bit to new nco_phase_mod is 1 clock. Symbol period is exactly L clocks.
- L=1: every RUN cycle is a boundary; one symbol per clock.
- Configuration changes on cfg_* during PRIME/RUN have no effect until the next IDLE->PRIME.
- nco_phase_mod and nco_phi_inc hold their values in IDLE. nco_phase_mod resets to 0 only on PRIME entry.

Optional Feature:
DQPSK_MODE_EN
- Defined:
  - bit_data is 2 bits; d is 2 bits.
  - On accept: d <= d + bit_data (mod 4).
  - nco_phase_mod = d << (ACC_W-2), giving quarter-cycle steps.
  - On underrun: dibit 0 is inserted and underrun is set.
- Undefined: 1-bit DPSK as described above.

Test Plan:
1. Reset mid-RUN → next edge: all outputs 0, state IDLE, busy=0.
2. cfg_phi_inc=34'h0C0000000, cfg_sym_len=4, enable=1, nco_valid rises 7 cycles after PRIME entry →
   - nco_clken high from the cycle after enable;
   - RUN entered on the first nco_valid;
   - first bit_ready exactly 4 clocks into RUN;
   - nco_phi_inc=34'h0C0000000.
3. Bits 1,0,1,1 always valid, L=4 →
   - nco_phase_mod sequence 0, 2^33, 2^33, 0, 2^33, each held 4 clocks;
   - sym_strobe period 4;
   - underrun=0.
4. bit_valid low at the second boundary (L=4) →
   - phase unchanged;
   - sym_strobe still pulses;
   - underrun=1 and stays 1 until the next IDLE->PRIME.
5. enable dropped at counter=1 of a symbol, L=4 →
   - symbol completes;
   - no bit accepted at the boundary;
   - nco_clken=0 one cycle after the boundary;
   - busy=0.
6. cfg_sym_len=0 → every RUN cycle has bit_ready=1. With DQPSK_MODE_EN, dibits 1,3,2 → nco_phase_mod 2^32, 0, 2^33.

Source files
------------

// File: rtl/dpsk_nco_sched_if.sv
// Source/NCO-side bundle for the DPSK symbol scheduler.
// DQPSK_MODE_EN widens bit_data to a dibit.
interface dpsk_nco_sched_if #(
  parameter int ACC_W = 34,
  parameter int LEN_W = 16
);
`ifdef DQPSK_MODE_EN
  localparam int DW = 2;
`else
  localparam int DW = 1;
`endif

  logic             enable;
  logic [ACC_W-1:0] cfg_phi_inc;
  logic [LEN_W-1:0] cfg_sym_len;
  logic [DW-1:0]    bit_data;
  logic             bit_valid;
  logic             bit_ready;
  logic [ACC_W-1:0] nco_phi_inc;
  logic [ACC_W-1:0] nco_phase_mod;
  logic             nco_clken;
  logic             nco_valid;
  logic             sym_strobe;
  logic             busy;
  logic             underrun;

  modport master (
    output enable, cfg_phi_inc, cfg_sym_len, bit_data, bit_valid, nco_valid,
    input  bit_ready, nco_phi_inc, nco_phase_mod, nco_clken, sym_strobe, busy, underrun
  );

  modport slave (
    input  enable, cfg_phi_inc, cfg_sym_len, bit_data, bit_valid, nco_valid,
    output bit_ready, nco_phi_inc, nco_phase_mod, nco_clken, sym_strobe, busy, underrun
  );
endinterface

// File: rtl/dpsk_nco_sched.sv
// DPSK symbol scheduler: primes the NCO, paces symbols, differentially encodes source bits.
// DQPSK_MODE_EN switches to dibit (quarter-cycle) differential encoding.
module dpsk_nco_sched #(
  parameter int ACC_W = 34,
  parameter int LEN_W = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  dpsk_nco_sched_if.slave bus
);
`ifdef DQPSK_MODE_EN
  localparam int DW = 2;
`else
  localparam int DW = 1;
`endif

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, lenm1_q, lenm1_d;
  logic [ACC_W-1:0] phi_q, pmod_q, pmod_d;
  logic [DW-1:0]    d_q, d_d;
  logic             strobe_q, under_q;
  logic             boundary, start, rdy, clken, busy;

  assign boundary = (state_q == S_RUN) && (cnt_q == lenm1_q);
  assign start    = (state_q == S_IDLE) && bus.enable;
  assign lenm1_d  = (bus.cfg_sym_len == '0) ? '0 : bus.cfg_sym_len - LEN_W'(1);
  // Underrun inserts symbol 0, which leaves the differential state unchanged.
  assign d_d      = bus.bit_valid ? d_q + bus.bit_data : d_q;
  assign pmod_d   = {d_d, {(ACC_W-DW){1'b0}}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.enable) state_d = S_PRIME;
      S_PRIME: if (!bus.enable) state_d = S_IDLE;
               else if (bus.nco_valid) state_d = S_RUN;
      S_RUN:   if (boundary && !bus.enable) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rdy   = 1'b0;
    clken = 1'b0;
    busy  = 1'b0;
    case (state_q)
      S_PRIME: begin clken = 1'b1; busy = 1'b1; end
      S_RUN:   begin clken = 1'b1; busy = 1'b1; rdy = boundary && bus.enable; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      lenm1_q  <= '0;
      phi_q    <= '0;
      pmod_q   <= '0;
      d_q      <= '0;
      strobe_q <= 1'b0;
      under_q  <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      if (start) begin
        phi_q   <= bus.cfg_phi_inc;
        lenm1_q <= lenm1_d;
        pmod_q  <= '0;
        d_q     <= '0;
        under_q <= 1'b0;
      end
      if (state_q == S_PRIME && bus.enable && bus.nco_valid)
        cnt_q <= '0;
      else if (state_q == S_RUN)
        cnt_q <= boundary ? '0 : cnt_q + LEN_W'(1);
      if (rdy) begin
        d_q      <= d_d;
        pmod_q   <= pmod_d;
        strobe_q <= 1'b1;
        if (!bus.bit_valid) under_q <= 1'b1;
      end
    end
  end

  assign bus.bit_ready     = rdy;
  assign bus.nco_clken     = clken;
  assign bus.busy          = busy;
  assign bus.nco_phi_inc   = phi_q;
  assign bus.nco_phase_mod = pmod_q;
  assign bus.sym_strobe    = strobe_q;
  assign bus.underrun      = under_q;
endmodule

// File: tb/tb_dpsk_nco_sched.sv
// Directed bench for dpsk_nco_sched: per-cycle vector table plus hand sequences.
// Expectations switch with DQPSK_MODE_EN.
module tb_dpsk_nco_sched;
  localparam int ACC_W = 34;
  localparam int LEN_W = 16;
`ifdef DQPSK_MODE_EN
  localparam int DW = 2;
`else
  localparam int DW = 1;
`endif
  localparam logic [ACC_W-1:0] P = 34'h200000000;
  localparam logic [ACC_W-1:0] Q = 34'h100000000;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  dpsk_nco_sched_if #(.ACC_W(ACC_W), .LEN_W(LEN_W)) bus ();
  dpsk_nco_sched #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));

  typedef struct {
    logic en, bv;
    logic [1:0] bd;
    logic nv;
    logic e_rdy, e_ck, e_st;
    logic [ACC_W-1:0] e_pm;
    logic e_busy, e_und;
  } vec_t;

  vec_t tbl[$];
  int n_chk = 0;
  int n_pass = 0;

  logic [1:0]       bits[6];
  logic             vlds[6];
  logic [ACC_W-1:0] pm[6];
  logic             und[6];
  logic [1:0]       b6[4];
  logic [ACC_W-1:0] e6[3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] outs();
    return 64'({bus.bit_ready, bus.nco_clken, bus.sym_strobe, bus.nco_phase_mod, bus.busy, bus.underrun});
  endfunction

  function automatic void add(input logic en, bv, input logic [1:0] bd, input logic nv,
                              input logic rdy, ck, st, input logic [ACC_W-1:0] p, input logic b, u);
    vec_t v;
    v.en = en; v.bv = bv; v.bd = bd; v.nv = nv;
    v.e_rdy = rdy; v.e_ck = ck; v.e_st = st; v.e_pm = p; v.e_busy = b; v.e_und = u;
    tbl.push_back(v);
  endfunction

  initial begin
    reset_n = 1'b0;
    bus.enable = 1'b0; bus.bit_valid = 1'b0; bus.bit_data = '0; bus.nco_valid = 1'b0;
    bus.cfg_phi_inc = 34'h0C0000000; bus.cfg_sym_len = 16'd4;

    vlds = '{1, 1, 1, 1, 0, 1};
    und  = '{0, 0, 0, 0, 1, 1};
`ifdef DQPSK_MODE_EN
    bits = '{1, 0, 1, 3, 0, 1};
    pm   = '{Q, Q, 2*Q, Q, Q, 2*Q};
    b6   = '{1, 3, 2, 0};
    e6   = '{Q, 34'h0, P};
`else
    bits = '{1, 0, 1, 1, 0, 1};
    pm   = '{P, P, 34'h0, P, P, 34'h0};
    b6   = '{1, 1, 0, 0};
    e6   = '{P, 34'h0, 34'h0};
`endif

    // IDLE with enable, then six PRIME cycles waiting, nco_valid on the seventh
    add(1, 0, 0, 0,  0, 0, 0, '0, 0, 0);
    for (int i = 1; i <= 6; i++) add(1, 0, 0, 0,  0, 1, 0, '0, 1, 0);
    add(1, 0, 0, 1,  0, 1, 0, '0, 1, 0);
    // Six L=4 symbols; the fifth boundary has no source bit
    for (int s = 0; s < 6; s++)
      for (int k = 0; k < 4; k++)
        add(1, (k == 3) ? vlds[s] : 1'b0, bits[s], 0,
            k == 3, 1, (k == 0) && (s > 0), (s == 0) ? '0 : pm[s-1], 1,
            (s == 0) ? 1'b0 : und[s-1]);
    add(1, 0, 0, 0,  0, 1, 1, pm[5], 1, und[5]);

    repeat (2) @(negedge clk);
    #1;
    check("reset_outs", outs(), 64'h0);
    check("reset_phi", 64'(bus.nco_phi_inc), 64'h0);
    @(negedge clk) reset_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      bus.enable = tbl[i].en; bus.bit_valid = tbl[i].bv;
      bus.bit_data = tbl[i].bd[DW-1:0]; bus.nco_valid = tbl[i].nv;
      // Mid-PRIME config change must not disturb the latched values
      if (i == 2) begin bus.cfg_phi_inc = 34'h000000003; bus.cfg_sym_len = 16'd2; end
      #1;
      check($sformatf("vec%0d", i),
            outs(), 64'({tbl[i].e_rdy, tbl[i].e_ck, tbl[i].e_st, tbl[i].e_pm, tbl[i].e_busy, tbl[i].e_und}));
    end
    check("phi_latched", 64'(bus.nco_phi_inc), 64'h0C0000000);

    // enable dropped at counter=1: symbol completes, boundary accepts nothing
    @(negedge clk);
    bus.enable = 1'b0; bus.bit_valid = 1'b1; bus.bit_data = DW'(1);
    #1 check("stop_cnt1_clken", 64'(bus.nco_clken), 64'h1);
    @(negedge clk);
    #1 check("stop_cnt2_busy", 64'(bus.busy), 64'h1);
    @(negedge clk);
    #1 check("stop_bnd_rdy", 64'(bus.bit_ready), 64'h0);
    check("stop_bnd_clken", 64'(bus.nco_clken), 64'h1);
    @(negedge clk);
    #1 check("stop_idle_clken", 64'(bus.nco_clken), 64'h0);
    check("stop_idle_busy", 64'(bus.busy), 64'h0);
    check("stop_idle_pmod", 64'(bus.nco_phase_mod), 64'(pm[5]));
    check("stop_idle_strobe", 64'(bus.sym_strobe), 64'h0);
    check("stop_idle_under", 64'(bus.underrun), 64'h1);

    // sym_len=0 runs as L=1: every RUN cycle is a boundary
    bus.bit_valid = 1'b0; bus.cfg_sym_len = 16'd0; bus.cfg_phi_inc = 34'h000001234;
    @(negedge clk);
    bus.enable = 1'b1;
    #1 check("l1_idle_busy", 64'(bus.busy), 64'h0);
    @(negedge clk);
    bus.nco_valid = 1'b1;
    #1 check("l1_prime", outs(), 64'({1'b0, 1'b1, 1'b0, {ACC_W{1'b0}}, 1'b1, 1'b0}));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.nco_valid = 1'b0; bus.bit_valid = (k < 3); bus.bit_data = b6[k][DW-1:0];
      #1 check($sformatf("l1_rdy%0d", k), 64'(bus.bit_ready), 64'h1);
      if (k > 0) begin
        check($sformatf("l1_pmod%0d", k), 64'(bus.nco_phase_mod), 64'(e6[k-1]));
        check($sformatf("l1_strobe%0d", k), 64'(bus.sym_strobe), 64'h1);
      end
    end
    check("l1_phi", 64'(bus.nco_phi_inc), 64'h000001234);
    check("l1_under", 64'(bus.underrun), 64'h0);

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    reset_n = 1'b0;
    #1 check("rst_run_outs", outs(), 64'h0);
    check("rst_run_phi", 64'(bus.nco_phi_inc), 64'h0);
    @(negedge clk);
    #1 check("rst_run_hold", outs(), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
